sample_test_arbiter: RTL and testbench

SAMPLE_TEST_ARBITER -- requirements
Module: sample_test_arbiter

---
 rtl/sample_test_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sample_test_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_test_arbiter.sv
// sample_test_arbiter: two-requester arbiter in front of a shared sample-test unit; routes returning hits to the requester that owned each accept.
// Latency: payload/valid/ready are combinational from the owner register; a grant takes effect on the next edge; a hit is routed in the cycle st_hit_valid arrives.
// Backpressure: st_ready low freezes the owner, the burst count and the payload selection, and the owner sees its ready low.
// Ports: clk/rst; req0_*/req1_* sample payloads with valid/ready; st_* muxed sample towards the shared unit;
//        st_hit_valid_R18H in, hit0/hit1 valid out; owner_R16H state, per-requester accept/hit counters, sticky orphan_err.
module sample_test_arbiter #(
   parameter int SIGFIG     = 24,
   parameter int VERTS      = 3,
   parameter int AXIS       = 3,
   parameter int COLORS     = 3,
   parameter int PIPE_DEPTH = 3,
   parameter int BURST      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0_valid_R16H,
   input  logic signed [SIGFIG-1:0] req0_tri_R16S    [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] req0_color_R16U  [COLORS],
   input  logic signed [SIGFIG-1:0] req0_sample_R16S [2],
   output logic                     req0_ready_R16H,
   input  logic                     req1_valid_R16H,
   input  logic signed [SIGFIG-1:0] req1_tri_R16S    [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] req1_color_R16U  [COLORS],
   input  logic signed [SIGFIG-1:0] req1_sample_R16S [2],
   output logic                     req1_ready_R16H,
   output logic                     st_valid_R16H,
   output logic signed [SIGFIG-1:0] st_tri_R16S      [VERTS][AXIS],
   output logic        [SIGFIG-1:0] st_color_R16U    [COLORS],
   output logic signed [SIGFIG-1:0] st_sample_R16S   [2],
   input  logic                     st_ready_R16H,
   input  logic                     st_hit_valid_R18H,
   output logic                     hit0_valid_R18H,
   output logic                     hit1_valid_R18H,
   output logic [1:0]               owner_R16H,
   output logic [31:0]              acc0_cnt,
   output logic [31:0]              acc1_cnt,
   output logic [31:0]              hit0_cnt,
   output logic [31:0]              hit1_cnt,
   output logic                     orphan_err
);

   localparam int             BW         = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BW-1:0]  BURST_LAST = BW'(BURST - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_last_owner;
   logic [BW-1:0]         r_burst_cnt;
   logic [PIPE_DEPTH-1:0] r_tag_vld;
   logic [PIPE_DEPTH-1:0] r_tag_id;
   logic [31:0]           r_acc0_cnt;
   logic [31:0]           r_acc1_cnt;
   logic [31:0]           r_hit0_cnt;
   logic [31:0]           r_hit1_cnt;
   logic                  r_orphan_err;

   logic   w_own0;
   logic   w_own1;
   logic   w_mine_vld;
   logic   w_other_vld;
   state_t w_other_state;
   logic   w_accept;
   logic   w_tag_out_vld;
   logic   w_tag_out_id;
   logic   w_hit0;
   logic   w_hit1;

   // Owner id used for tagging and last_owner is simply "owner is requester 1".
   assign w_own0        = (r_state == ST_OWN0);
   assign w_own1        = (r_state == ST_OWN1);
   assign w_mine_vld    = w_own1 ? req1_valid_R16H : req0_valid_R16H;
   assign w_other_vld   = w_own1 ? req0_valid_R16H : req1_valid_R16H;
   assign w_other_state = w_own1 ? ST_OWN0 : ST_OWN1;

   assign st_valid_R16H   = (w_own0 & req0_valid_R16H) | (w_own1 & req1_valid_R16H);
   assign req0_ready_R16H = w_own0 & st_ready_R16H;
   assign req1_ready_R16H = w_own1 & st_ready_R16H;
   assign w_accept        = st_valid_R16H & st_ready_R16H;

   // Payload follows the owner register only, so it cannot change under a stall.
   always_comb begin
      if (w_own1) begin
         st_tri_R16S    = req1_tri_R16S;
         st_color_R16U  = req1_color_R16U;
         st_sample_R16S = req1_sample_R16S;
      end else begin
         st_tri_R16S    = req0_tri_R16S;
         st_color_R16U  = req0_color_R16U;
         st_sample_R16S = req0_sample_R16S;
      end
   end

   // Ownership FSM. A burst ends either when the owner drops valid or when it
   // has taken BURST samples while the other side waits; with nobody waiting the
   // owner keeps the unit and the burst count just restarts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_last_owner <= 1'b1;
         r_burst_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_burst_cnt <= '0;
               if (req0_valid_R16H && (!req1_valid_R16H || r_last_owner)) begin
                  r_state <= ST_OWN0;
               end else if (req1_valid_R16H) begin
                  r_state <= ST_OWN1;
               end
            end
            ST_OWN0, ST_OWN1: begin
               if (!w_mine_vld) begin
                  r_state      <= w_other_vld ? w_other_state : ST_IDLE;
                  r_last_owner <= w_own1;
                  r_burst_cnt  <= '0;
               end else if (w_accept) begin
                  if (r_burst_cnt == BURST_LAST) begin
                     r_burst_cnt <= '0;
                     if (w_other_vld) begin
                        r_state      <= w_other_state;
                        r_last_owner <= w_own1;
                     end
                  end else begin
                     r_burst_cnt <= r_burst_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_burst_cnt <= '0;
            end
         endcase
      end
   end

   // Tag pipe mirrors the shared unit's fixed latency: it shifts every cycle,
   // stalled or not, so the tag leaving it lines up with the returning hit.
   assign w_tag_out_vld   = r_tag_vld[PIPE_DEPTH-1];
   assign w_tag_out_id    = r_tag_id[PIPE_DEPTH-1];
   assign w_hit0          = st_hit_valid_R18H & w_tag_out_vld & ~w_tag_out_id;
   assign w_hit1          = st_hit_valid_R18H & w_tag_out_vld &  w_tag_out_id;
   assign hit0_valid_R18H = w_hit0;
   assign hit1_valid_R18H = w_hit1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag_vld    <= '0;
         r_tag_id     <= '0;
         r_acc0_cnt   <= '0;
         r_acc1_cnt   <= '0;
         r_hit0_cnt   <= '0;
         r_hit1_cnt   <= '0;
         r_orphan_err <= 1'b0;
      end else begin
         r_tag_vld <= (r_tag_vld << 1) | PIPE_DEPTH'(w_accept);
         r_tag_id  <= (r_tag_id << 1)  | PIPE_DEPTH'(w_own1);
         if (w_accept && w_own0) r_acc0_cnt <= r_acc0_cnt + 32'd1;
         if (w_accept && w_own1) r_acc1_cnt <= r_acc1_cnt + 32'd1;
         if (w_hit0)             r_hit0_cnt <= r_hit0_cnt + 32'd1;
         if (w_hit1)             r_hit1_cnt <= r_hit1_cnt + 32'd1;
         // A hit with no tag behind it is dropped but remembered.
         if (st_hit_valid_R18H && !w_tag_out_vld) r_orphan_err <= 1'b1;
      end
   end

   assign owner_R16H = r_state;
   assign acc0_cnt   = r_acc0_cnt;
   assign acc1_cnt   = r_acc1_cnt;
   assign hit0_cnt   = r_hit0_cnt;
   assign hit1_cnt   = r_hit1_cnt;
   assign orphan_err = r_orphan_err;

endmodule

// File: tb/tb_sample_test_arbiter.sv
// tb_sample_test_arbiter: table-driven cycle vectors for sample_test_arbiter with a hit-routing scoreboard.
// Each row is one clock: inputs driven just after the falling edge, outputs sampled 1ns later.
// Expected hits are queued when an accept is expected and matched when the DUT raises hitN_valid.
module tb_sample_test_arbiter;

   localparam int SIGFIG     = 24;
   localparam int VERTS      = 3;
   localparam int AXIS       = 3;
   localparam int COLORS     = 3;
   localparam int PIPE_DEPTH = 3;
   localparam int BURST      = 4;

   logic clk;
   logic rst;
   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic signed [SIGFIG-1:0] req0_tri [VERTS][AXIS];
   logic signed [SIGFIG-1:0] req1_tri [VERTS][AXIS];
   logic        [SIGFIG-1:0] req0_color [COLORS];
   logic        [SIGFIG-1:0] req1_color [COLORS];
   logic signed [SIGFIG-1:0] req0_sample [2];
   logic signed [SIGFIG-1:0] req1_sample [2];
   logic st_valid, st_ready, st_hit_valid, hit0_valid, hit1_valid, orphan_err;
   logic signed [SIGFIG-1:0] st_tri [VERTS][AXIS];
   logic        [SIGFIG-1:0] st_color [COLORS];
   logic signed [SIGFIG-1:0] st_sample [2];
   logic [1:0]  owner;
   logic [31:0] acc0_cnt, acc1_cnt, hit0_cnt, hit1_cnt;

   sample_test_arbiter #(
      .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
      .PIPE_DEPTH(PIPE_DEPTH), .BURST(BURST)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid_R16H(req0_valid), .req0_tri_R16S(req0_tri), .req0_color_R16U(req0_color),
      .req0_sample_R16S(req0_sample), .req0_ready_R16H(req0_ready),
      .req1_valid_R16H(req1_valid), .req1_tri_R16S(req1_tri), .req1_color_R16U(req1_color),
      .req1_sample_R16S(req1_sample), .req1_ready_R16H(req1_ready),
      .st_valid_R16H(st_valid), .st_tri_R16S(st_tri), .st_color_R16U(st_color),
      .st_sample_R16S(st_sample), .st_ready_R16H(st_ready),
      .st_hit_valid_R18H(st_hit_valid), .hit0_valid_R18H(hit0_valid), .hit1_valid_R18H(hit1_valid),
      .owner_R16H(owner), .acc0_cnt(acc0_cnt), .acc1_cnt(acc1_cnt),
      .hit0_cnt(hit0_cnt), .hit1_cnt(hit1_cnt), .orphan_err(orphan_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rstn, v0, v1, sr, hv;
      logic [1:0]  own;
      logic        stv, r0, r1, h0, h1;
      logic        chk;
      logic [31:0] a0, a1, c0, c1;
      logic        orph;
   } vec_t;

   typedef struct packed {
      int   due;
      logic id;
   } tag_t;

   vec_t tbl[$];
   tag_t sb[$];
   vec_t t;
   tag_t e_tag;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   own_k;
   int   bad;
   int   rq;
   logic [6:0] got_v, exp_v;
   logic [1:0] got_h, exp_h;
   logic       sb_due;

   function automatic logic [23:0] tri_val(input int r, input int v, input int a);
      int x;
      x = (r == 1) ? -(2000 + v * 10 + a) : (1000 + v * 10 + a);
      return x[23:0];
   endfunction

   function automatic logic [23:0] color_val(input int r, input int c);
      return (r == 1) ? (24'hA00000 + 24'(c)) : (24'h000100 + 24'(c));
   endfunction

   function automatic logic [23:0] sample_val(input int r, input int i);
      int x;
      if (r == 1) x = (i == 0) ? -21 : 22;
      else        x = (i == 0) ? 11 : -12;
      return x[23:0];
   endfunction

   task automatic add(input int rstn, input int v0, input int v1, input int sr, input int hv,
                      input int own, input int stv, input int r0, input int r1,
                      input int h0, input int h1);
      vec_t e;
      e      = '0;
      e.rstn = (rstn != 0); e.v0 = (v0 != 0); e.v1 = (v1 != 0);
      e.sr   = (sr != 0);   e.hv = (hv != 0);
      e.own  = 2'(own);     e.stv = (stv != 0);
      e.r0   = (r0 != 0);   e.r1 = (r1 != 0);
      e.h0   = (h0 != 0);   e.h1 = (h1 != 0);
      tbl.push_back(e);
   endtask

   // Attach expected counter values to the most recently added row.
   task automatic cnt(input int a0, input int a1, input int c0, input int c1, input int orph);
      vec_t e;
      e      = tbl.pop_back();
      e.chk  = 1'b1;
      e.a0   = a0; e.a1 = a1; e.c0 = c0; e.c1 = c1;
      e.orph = (orph != 0);
      tbl.push_back(e);
   endtask

   task automatic chk32(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row%0d: got %0d, want %0d", nm, row, got, exp);
      end
   endtask

   initial begin
      // Reset with everything asserted; nothing may leak through.
      add(0, 1,1,1,1, 0,0,0,0,0,0); cnt(0,0,0,0,0);
      // Both requesters saturating: bursts of four, alternating, no bubbles.
      add(1, 1,1,1,0, 0,0,0,0,0,0);
      for (int k = 1; k <= 17; k++) begin
         own_k = (((k - 1) / BURST) % 2 == 0) ? 1 : 2;
         add(1, 1,1,1,0, own_k,1,(own_k == 1) ? 1 : 0,(own_k == 2) ? 1 : 0,0,0);
      end
      cnt(8,8,0,0,0);

      // Only req1 for ten cycles, then a routed hit and an orphan hit.
      add(0, 0,0,0,0, 0,0,0,0,0,0); cnt(0,0,0,0,0);
      add(1, 0,1,1,0, 0,0,0,0,0,0);
      for (int k = 1; k <= 9; k++) add(1, 0,1,1,0, 2,1,0,1,0,0);
      add(1, 0,0,1,0, 2,0,0,1,0,0); cnt(0,9,0,0,0);
      add(1, 0,0,1,0, 0,0,0,0,0,0);
      add(1, 0,0,1,1, 0,0,0,0,0,1);
      add(1, 0,0,1,1, 0,0,0,0,0,0);
      add(1, 0,0,1,0, 0,0,0,0,0,0); cnt(0,9,0,1,1);
      add(1, 0,0,1,0, 0,0,0,0,0,0); cnt(0,9,0,1,1);

      // Stall mid-burst, burst resumes at the same count, then hit routing.
      add(0, 0,0,0,0, 0,0,0,0,0,0); cnt(0,0,0,0,0);
      add(1, 1,0,1,0, 0,0,0,0,0,0);
      add(1, 1,0,1,0, 1,1,1,0,0,0);
      add(1, 1,0,1,0, 1,1,1,0,0,0);
      for (int k = 0; k < 3; k++) add(1, 1,1,0,0, 1,1,0,0,0,0);
      add(1, 1,1,1,0, 1,1,1,0,0,0); cnt(2,0,0,0,0);
      add(1, 1,1,1,0, 1,1,1,0,0,0);
      add(1, 1,1,1,0, 2,1,0,1,0,0);
      add(1, 1,0,1,0, 2,0,0,1,0,0);
      add(1, 1,0,1,1, 1,1,1,0,1,0);
      add(1, 0,0,1,1, 1,0,1,0,0,1);
      add(1, 0,0,1,0, 0,0,0,0,0,0);
      add(1, 0,0,1,1, 0,0,0,0,1,0);
      add(1, 0,0,1,0, 0,0,0,0,0,0); cnt(5,1,2,1,0);

      // Reset while OWN1 with two tags in flight; the next tie goes to req0.
      add(0, 0,0,0,0, 0,0,0,0,0,0); cnt(0,0,0,0,0);
      add(1, 0,1,1,0, 0,0,0,0,0,0);
      add(1, 0,1,1,0, 2,1,0,1,0,0);
      add(1, 0,1,1,0, 2,1,0,1,0,0);
      add(0, 1,1,1,1, 0,0,0,0,0,0); cnt(0,0,0,0,0);
      add(1, 1,1,1,0, 0,0,0,0,0,0);
      add(1, 1,1,1,0, 1,1,1,0,0,0);
      add(1, 1,1,1,0, 1,1,1,0,0,0); cnt(1,0,0,0,0);

      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++) begin
            req0_tri[v][a] = tri_val(0, v, a);
            req1_tri[v][a] = tri_val(1, v, a);
         end
      for (int c = 0; c < COLORS; c++) begin
         req0_color[c] = color_val(0, c);
         req1_color[c] = color_val(1, c);
      end
      for (int i = 0; i < 2; i++) begin
         req0_sample[i] = sample_val(0, i);
         req1_sample[i] = sample_val(1, i);
      end
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      st_ready = 1'b0; st_hit_valid = 1'b0;

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         t            = tbl[i];
         rst          = t.rstn;
         req0_valid   = t.v0;
         req1_valid   = t.v1;
         st_ready     = t.sr;
         st_hit_valid = t.hv;
         #1;
         if (!t.rstn) sb.delete();

         got_v = {owner, st_valid, req0_ready, req1_ready, hit0_valid, hit1_valid};
         exp_v = {t.own, t.stv, t.r0, t.r1, t.h0, t.h1};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL outputs row%0d: got own=%0d vld=%b rdy0=%b rdy1=%b hit0=%b hit1=%b, want own=%0d vld=%b rdy0=%b rdy1=%b hit0=%b hit1=%b",
                     i, got_v[6:5], got_v[4], got_v[3], got_v[2], got_v[1], got_v[0],
                     exp_v[6:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end

         if (t.rstn && t.own != 2'd0) begin
            rq  = (t.own == 2'd2) ? 1 : 0;
            bad = 0;
            for (int v = 0; v < VERTS; v++)
               for (int a = 0; a < AXIS; a++)
                  if (st_tri[v][a] !== tri_val(rq, v, a)) bad++;
            for (int c = 0; c < COLORS; c++)
               if (st_color[c] !== color_val(rq, c)) bad++;
            for (int s = 0; s < 2; s++)
               if (st_sample[s] !== sample_val(rq, s)) bad++;
            checks++;
            if (bad != 0) begin
               errors++;
               $display("FAIL payload row%0d: %0d fields differ, st_sample[0]=%0h want %0h (req%0d)",
                        i, bad, st_sample[0], sample_val(rq, 0), rq);
            end
         end

         // Hit scoreboard: a tag is due PIPE_DEPTH cycles after its accept.
         while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
         sb_due = t.hv && sb.size() > 0 && sb[0].due == cyc;
         exp_h  = sb_due ? (sb[0].id ? 2'b01 : 2'b10) : 2'b00;
         got_h  = {hit0_valid, hit1_valid};
         if (got_h != 2'b00 || exp_h != 2'b00) begin
            checks++;
            if (got_h !== exp_h) begin
               errors++;
               $display("FAIL hit_route row%0d: got hit0/hit1=%b, want %b", i, got_h, exp_h);
            end
         end
         if (sb_due) void'(sb.pop_front());
         if (t.rstn && t.stv && t.sr && t.own != 2'd0) begin
            e_tag.due = cyc + PIPE_DEPTH;
            e_tag.id  = (t.own == 2'd2);
            sb.push_back(e_tag);
         end

         if (t.chk) begin
            chk32("acc0_cnt", i, acc0_cnt, t.a0);
            chk32("acc1_cnt", i, acc1_cnt, t.a1);
            chk32("hit0_cnt", i, hit0_cnt, t.c0);
            chk32("hit1_cnt", i, hit1_cnt, t.c1);
            chk32("orphan_err", i, {31'd0, orphan_err}, {31'd0, t.orph});
         end

         cyc++;
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
